// File: rtl/uart_core.sv
// UART core: shared baud tick, one transmitter, one receiver with majority-vote
// sampling and break handling, and a first-word fall-through receive FIFO.
module uart_core #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);

    localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIVW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] SMP_A   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] SMP_B   = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] SMP_C   = OSW'(OVERSAMPLE / 2 + 1);

    localparam logic [2:0] DB_LAST    = 3'(DATA_BITS - 1);
    localparam logic       SB_LAST    = 1'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);
    localparam bit         ODD        = (PARITY == 1);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rxState_t;

    logic [DIVW-1:0] tickCnt;
    logic            tick;

    txState_t             txState;
    logic [OSW-1:0]       txOs;
    logic [2:0]           txBit;
    logic                 txStop;
    logic [DATA_BITS-1:0] txShift;
    logic                 txParBit;
    logic                 txArmed;
    logic                 txdReg;
    logic                 txReadyReg;

    logic                 rxMeta;
    logic                 rxSync;
    rxState_t             rxState;
    logic [OSW-1:0]       rxOs;
    logic [2:0]           rxBit;
    logic [DATA_BITS-1:0] rxShift;
    logic                 rxParErr;
    logic [1:0]           rxVote;
    logic                 rxMajority;
    logic                 rxExpPar;
    logic                 rxPush;
    logic [WW-1:0]        rxWord;

    logic [WW-1:0] fifoMem [FIFO_DEPTH];
    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtr;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          fifoPop;
    logic          fifoWrite;
    logic [WW-1:0] fifoHead;
    logic          rxOverrunReg;

    assign tick = (tickCnt == DIV_LAST);

    // Free-running divider producing one oversample tick every DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tickCnt <= '0;
        end else if (tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    // Transmitter: waits for a tick before driving the start bit so every bit,
    // including the first, spans exactly OVERSAMPLE ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState    <= TX_IDLE;
            txOs       <= '0;
            txBit      <= '0;
            txStop     <= 1'b0;
            txShift    <= '0;
            txParBit   <= 1'b0;
            txArmed    <= 1'b0;
            txdReg     <= 1'b1;
            txReadyReg <= 1'b1;
        end else begin
            case (txState)
                TX_IDLE: begin
                    if (tx_valid) begin
                        txShift    <= tx_data;
                        txParBit   <= ODD ? ~^tx_data : ^tx_data;
                        txReadyReg <= 1'b0;
                        txArmed    <= 1'b1;
                        txOs       <= '0;
                        txState    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (txArmed) begin
                            txArmed <= 1'b0;
                            txdReg  <= 1'b0;
                            txOs    <= '0;
                        end else begin
                            txOs <= txOs + 1'b1;
                            if (txOs == OS_LAST) begin
                                txdReg  <= txShift[0];
                                txBit   <= '0;
                                txState <= TX_DATA;
                            end
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        txOs <= txOs + 1'b1;
                        if (txOs == OS_LAST) begin
                            if (txBit == DB_LAST) begin
                                if (HAS_PARITY) begin
                                    txdReg  <= txParBit;
                                    txState <= TX_PARITY;
                                end else begin
                                    txdReg  <= 1'b1;
                                    txStop  <= 1'b0;
                                    txState <= TX_STOP;
                                end
                            end else begin
                                txBit   <= txBit + 1'b1;
                                txShift <= txShift >> 1;
                                txdReg  <= txShift[1];
                            end
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        txOs <= txOs + 1'b1;
                        if (txOs == OS_LAST) begin
                            txdReg  <= 1'b1;
                            txStop  <= 1'b0;
                            txState <= TX_STOP;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        txOs <= txOs + 1'b1;
                        if (txOs == OS_LAST) begin
                            if (txStop == SB_LAST) begin
                                txReadyReg <= 1'b1;
                                txState    <= TX_IDLE;
                            end else begin
                                txStop <= txStop + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    txdReg     <= 1'b1;
                    txReadyReg <= 1'b1;
                    txState    <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxSync <= rxMeta;
        end
    end

    assign rxMajority = (rxVote[0] & rxVote[1]) | (rxVote[0] & rxSync) | (rxVote[1] & rxSync);
    assign rxExpPar   = ODD ? ~^rxShift : ^rxShift;

    // Receiver: rxOs holds the index of the current tick within the bit; votes are
    // taken around the bit centre and the decision is made on the third sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxState  <= RX_IDLE;
            rxOs     <= '0;
            rxBit    <= '0;
            rxShift  <= '0;
            rxParErr <= 1'b0;
            rxVote   <= 2'b11;
            rxPush   <= 1'b0;
            rxWord   <= '0;
        end else begin
            rxPush <= 1'b0;
            case (rxState)
                RX_IDLE: begin
                    if (tick && !rxSync) begin
                        rxOs     <= OSW'(1);
                        rxBit    <= '0;
                        rxParErr <= 1'b0;
                        rxState  <= RX_START;
                    end
                end
                RX_BREAK: begin
                    if (tick) begin
                        if (!rxSync) begin
                            rxOs <= '0;
                        end else if (rxOs == OS_LAST) begin
                            rxOs    <= '0;
                            rxState <= RX_IDLE;
                        end else begin
                            rxOs <= rxOs + 1'b1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        rxOs <= rxOs + 1'b1;
                        if (rxOs == SMP_A) rxVote[0] <= rxSync;
                        if (rxOs == SMP_B) rxVote[1] <= rxSync;
                        if (rxOs == SMP_C) begin
                            if (rxState == RX_START) begin
                                if (rxMajority) rxState <= RX_IDLE;
                            end else if (rxState == RX_DATA) begin
                                rxShift <= {rxMajority, rxShift[DATA_BITS-1:1]};
                            end else if (rxState == RX_PARITY) begin
                                rxParErr <= (rxMajority != rxExpPar);
                            end else begin
                                rxPush  <= 1'b1;
                                rxWord  <= {~rxMajority, rxParErr, rxShift};
                                rxOs    <= '0;
                                rxState <= (!rxMajority && rxShift == '0) ? RX_BREAK : RX_IDLE;
                            end
                        end
                        if (rxOs == OS_LAST) begin
                            if (rxState == RX_START) begin
                                rxBit   <= '0;
                                rxState <= RX_DATA;
                            end else if (rxState == RX_DATA) begin
                                if (rxBit == DB_LAST) begin
                                    rxState <= HAS_PARITY ? RX_PARITY : RX_STOP;
                                end else begin
                                    rxBit <= rxBit + 1'b1;
                                end
                            end else if (rxState == RX_PARITY) begin
                                rxState <= RX_STOP;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign fifoPop   = !fifoEmpty && rx_ready;
    assign fifoWrite = rxPush && (!fifoFull || fifoPop);
    assign fifoHead  = fifoMem[rdPtr[AW-1:0]];

    // FIFO pointers and the overrun pulse for a word arriving into a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            rxOverrunReg <= 1'b0;
        end else begin
            if (fifoWrite) wrPtr <= wrPtr + 1'b1;
            if (fifoPop)   rdPtr <= rdPtr + 1'b1;
            rxOverrunReg <= rxPush && fifoFull && !fifoPop;
        end
    end

    // FIFO storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (fifoWrite) fifoMem[wrPtr[AW-1:0]] <= rxWord;
    end

    assign tx_ready      = txReadyReg;
    assign txd           = txdReg;
    assign rx_valid      = !fifoEmpty;
    assign rx_data       = rx_valid ? fifoHead[DATA_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid & fifoHead[DATA_BITS];
    assign rx_frame_err  = rx_valid & fifoHead[DATA_BITS+1];
    assign rx_overrun    = rxOverrunReg;

endmodule

// File: tb/tb_uart_core.sv
// Testbench for uart_core: even parity, 8 data bits, 2 clocks per tick (32 clocks
// per bit). Expected frames are built from a bit-list model of the line format.
module tb_uart_core;

    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;

    logic loopMode = 1'b0;
    logic rxLine = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   overrunCount = 0;

    assign rxd = loopMode ? txd : rxLine;

    uart_core #(
        .CLK_FREQ(3686400), .BAUD(115200), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .rxd(rxd), .rx_data(rx_data),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Counts overrun pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_overrun) overrunCount++;
    end

    function automatic logic evenPar(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    // Line bits in transmission order: start, data LSB first, parity, stop.
    function automatic logic [10:0] frameBits(input logic [7:0] d, input logic par, input logic stopBit);
        return {stopBit, par, d, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("txReadyWait", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic waitRxValid(input int maxCycles);
        int n = 0;
        while (!rx_valid && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rxValidWait", rx_valid, 1);
    endtask

    task automatic popRx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic expectWord(input string tag, input logic [7:0] d, input logic perr, input logic ferr);
        waitRxValid(800);
        checkOutput({tag, "Data"}, rx_data, d);
        checkOutput({tag, "ParErr"}, rx_parity_err, perr);
        checkOutput({tag, "FrameErr"}, rx_frame_err, ferr);
        popRx();
    endtask

    task automatic driveFrame(input logic [7:0] d, input logic par, input logic stopBit, input int stopClks);
        logic [10:0] bits;
        bits = frameBits(d, par, stopBit);
        for (int k = 0; k < 10; k++) begin
            rxLine = bits[k];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxLine = bits[10];
        repeat (stopClks) @(negedge clk);
        rxLine = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  d;
        logic [10:0] bits;
        logic [7:0]  kept [$];
        int          offset;
        int          ovBase;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstTxd", txd, 1);
        checkOutput("rstTxReady", tx_ready, 1);
        checkOutput("rstRxValid", rx_valid, 0);
        checkOutput("rstRxData", rx_data, 0);
        checkOutput("rstParErr", rx_parity_err, 0);
        checkOutput("rstFrameErr", rx_frame_err, 0);
        checkOutput("rstOverrun", rx_overrun, 0);

        // Transmit waveform for 0xA5, looped back into the receiver
        $display("[TB] transmit waveform");
        loopMode = 1'b1;
        d = 8'hA5;
        bits = frameBits(d, evenPar(d), 1'b1);
        applyStimulus(d);
        checkOutput("txReadyDrop", tx_ready, 0);
        offset = 0;
        while (txd && offset < 100) begin
            @(negedge clk);
            offset++;
        end
        checkOutput("txStartSeen", txd, 0);
        offset = 0;
        for (int k = 0; k < 11; k++) begin
            repeat (16 + BIT_CLKS * k - offset) @(negedge clk);
            offset = 16 + BIT_CLKS * k;
            checkOutput($sformatf("txBit%0d", k), txd, bits[k]);
        end
        while (!tx_ready && offset < 500) begin
            @(negedge clk);
            offset++;
        end
        checkOutput("txReadyReturn", offset, 11 * BIT_CLKS);
        expectWord("loopA5", d, 1'b0, 1'b0);

        // Loopback of boundary and random characters
        $display("[TB] loopback");
        for (int i = 0; i < 24; i++) begin
            d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
            applyStimulus(d);
            expectWord("loop", d, 1'b0, 1'b0);
        end
        checkOutput("loopEmpty", rx_valid, 0);
        loopMode = 1'b0;
        repeat (64) @(negedge clk);

        // Wrong parity, good frame, bad stop bit
        $display("[TB] receive errors");
        driveFrame(8'h3C, ~evenPar(8'h3C), 1'b1, BIT_CLKS);
        expectWord("parInject", 8'h3C, 1'b1, 1'b0);
        d = 8'($urandom);
        driveFrame(d, evenPar(d), 1'b1, BIT_CLKS);
        expectWord("goodFrame", d, 1'b0, 1'b0);
        d = 8'($urandom) | 8'h01;
        driveFrame(d, evenPar(d), 1'b0, 24);
        expectWord("stopInject", d, 1'b0, 1'b1);
        repeat (64) @(negedge clk);
        checkOutput("noWriteAfterFrameErr", rx_valid, 0);

        // Short low glitch must not start a character
        rxLine = 1'b0;
        repeat (6) @(negedge clk);
        rxLine = 1'b1;
        repeat (96) @(negedge clk);
        checkOutput("falseStart", rx_valid, 0);

        // Break: long low, then a short high blip that must not leave BREAK
        $display("[TB] break");
        rxLine = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        expectWord("break", 8'h00, 1'b0, 1'b1);
        rxLine = 1'b1;
        repeat (10) @(negedge clk);
        rxLine = 1'b0;
        repeat (40) @(negedge clk);
        rxLine = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("breakHold", rx_valid, 0);
        d = 8'($urandom);
        driveFrame(d, evenPar(d), 1'b1, BIT_CLKS);
        expectWord("afterBreak", d, 1'b0, 1'b0);

        // Overrun with the consumer stalled
        $display("[TB] overrun");
        ovBase = overrunCount;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (i < 4) kept.push_back(d);
            driveFrame(d, evenPar(d), 1'b1, BIT_CLKS);
            if (i == 3) checkOutput("overrunBefore5th", overrunCount - ovBase, 0);
        end
        checkOutput("overrunPulses", overrunCount - ovBase, 1);
        checkOutput("fullValid", rx_valid, 1);
        for (int i = 0; i < 4; i++) begin
            expectWord($sformatf("kept%0d", i), kept[i], 1'b0, 1'b0);
        end
        checkOutput("drainedEmpty", rx_valid, 0);

        // Reset in the middle of a looped-back character
        $display("[TB] reset mid character");
        loopMode = 1'b1;
        applyStimulus(8'($urandom));
        repeat (150) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midRstTxd", txd, 1);
        checkOutput("midRstTxReady", tx_ready, 1);
        checkOutput("midRstEmpty", rx_valid, 0);
        repeat (400) @(negedge clk);
        checkOutput("midRstNoPartial", rx_valid, 0);
        d = 8'($urandom);
        applyStimulus(d);
        expectWord("afterRst", d, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
